// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, block geometry, and the
// IV / round constants used by the compression core.
package sha256_pkg;

  localparam int unsigned BLOCK_BITS  = 512;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned LEN_POS     = 56;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned CNT_W       = 64;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD1 = 2'd1,
    ST_PAD2 = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  localparam logic [31:0] SHA_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_msg_padder.sv
// Byte-stream to 512-bit block padder (0x80, zero fill, 64-bit bit length)
// feeding the SHA-256 compression core over a valid/ready port.
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [7:0]            msg_byte,
  input  logic                  msg_last,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [BLOCK_BITS-1:0] blk_data,
  output logic                  blk_first,
  output logic                  blk_last
);

  state_e                 state;
  state_e                 pend;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       q;
  logic [CNT_W-1:0]       byte_cnt;
  logic [CNT_W-1:0]       bit_len;
  logic                   first_flag;
  logic [BLOCK_BITS-1:0]  buf_q;
  logic [BLOCK_BITS-1:0]  buf_d;
  logic                   fill_acc;
  logic                   len_in_pad1;

  assign fill_acc    = (state == ST_FILL) && msg_valid;
  assign bit_len     = {byte_cnt[CNT_W-4:0], 3'b000};
  assign len_in_pad1 = (q <= IDX_W'(LEN_POS - 1));
  assign blk_data    = buf_q;

  // Byte-write mux and pad mask; byte k lives at bits [511-8k -: 8].
  always_comb begin
    buf_d = buf_q;
    for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
      if (fill_acc && (IDX_W'(k) == idx)) begin
        buf_d[8*(BLOCK_BYTES-1-k) +: 8] = msg_byte;
      end else if (state == ST_PAD1) begin
        if (IDX_W'(k) == q) begin
          buf_d[8*(BLOCK_BYTES-1-k) +: 8] = 8'h80;
        end else if (IDX_W'(k) > q) begin
          if (len_in_pad1 && (k >= LEN_POS)) begin
            buf_d[8*(BLOCK_BYTES-1-k) +: 8] = 8'(bit_len >> (8*(BLOCK_BYTES-1-k)));
          end else begin
            buf_d[8*(BLOCK_BYTES-1-k) +: 8] = 8'h00;
          end
        end
      end else if (state == ST_PAD2) begin
        if (k >= LEN_POS) begin
          buf_d[8*(BLOCK_BYTES-1-k) +: 8] = 8'(bit_len >> (8*(BLOCK_BYTES-1-k)));
        end else begin
          buf_d[8*(BLOCK_BYTES-1-k) +: 8] = 8'h00;
        end
      end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      pend       <= ST_FILL;
      idx        <= '0;
      q          <= '0;
      byte_cnt   <= '0;
      first_flag <= 1'b1;
      buf_q      <= '0;
      msg_ready  <= 1'b1;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
    end else begin
      buf_q <= buf_d;
      case (state)
        ST_FILL: begin
          if (msg_valid) begin
            idx      <= idx + IDX_W'(1);
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (msg_last) begin
              msg_ready <= 1'b0;
              if (idx == IDX_W'(BLOCK_BYTES - 1)) begin
                state     <= ST_EMIT;
                pend      <= ST_PAD1;
                q         <= '0;
                blk_valid <= 1'b1;
                blk_first <= first_flag;
                blk_last  <= 1'b0;
              end else begin
                state <= ST_PAD1;
                q     <= idx + IDX_W'(1);
              end
            end else if (idx == IDX_W'(BLOCK_BYTES - 1)) begin
              state     <= ST_EMIT;
              pend      <= ST_FILL;
              msg_ready <= 1'b0;
              blk_valid <= 1'b1;
              blk_first <= first_flag;
              blk_last  <= 1'b0;
            end
          end
        end
        ST_PAD1: begin
          state     <= ST_EMIT;
          blk_valid <= 1'b1;
          blk_first <= first_flag;
          if (len_in_pad1) begin
            blk_last <= 1'b1;
            pend     <= ST_FILL;
          end else begin
            blk_last <= 1'b0;
            pend     <= ST_PAD2;
          end
        end
        ST_PAD2: begin
          state     <= ST_EMIT;
          pend      <= ST_FILL;
          blk_valid <= 1'b1;
          blk_first <= first_flag;
          blk_last  <= 1'b1;
        end
        ST_EMIT: begin
          if (blk_ready) begin
            state     <= pend;
            idx       <= '0;
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            msg_ready <= (pend == ST_FILL);
            // A consumed last block closes the message: restart length and IV.
            if (blk_last) begin
              first_flag <= 1'b1;
              byte_cnt   <= '0;
            end else begin
              first_flag <= 1'b0;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed table, hand-written corner sequences,
// and random messages scored against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  typedef logic [7:0] byte_t;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  typedef struct {
    int          len;
    byte_t       fill;
    int          nblk;
    logic [31:0] w0;
    logic [31:0] w13;
    logic [31:0] w15;
    int          lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_valid;
  logic         msg_ready;
  logic [7:0]   msg_byte;
  logic         msg_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  sha256_msg_padder dut (
    .clk       (clk),
    .reset     (reset),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_byte  (msg_byte),
    .msg_last  (msg_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  blk_t         exp_q[$];
  int           blk_cnt      = 0;
  int           last_acc_cyc = 0;
  int           last_blk_cyc = 0;
  logic [511:0] last_data    = '0;
  logic         last_first   = 1'b0;
  logic         last_last    = 1'b0;
  logic         hold_vld     = 1'b0;
  logic [511:0] hold_data    = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 2) blk_ready = ($urandom_range(0, 3) != 0);
    else               blk_ready = (rdy_mode == 1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_data(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] word(input logic [511:0] d, input int i);
    return d[511-32*i -: 32];
  endfunction

  // Reference: pad the whole message, then slice into 64-byte blocks.
  task automatic model_push(input byte_t m[$]);
    byte_t       p[$];
    logic [63:0] bl;
    blk_t        b;
    int          nb;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
    nb = p.size() / 64;
    for (int bi = 0; bi < nb; bi++) begin
      for (int k = 0; k < 64; k++) b.data[511-8*k -: 8] = p[64*bi + k];
      b.first = (bi == 0);
      b.last  = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  // Output monitor: scoreboard, stall stability and latency stamps.
  always @(negedge clk) begin
    if (reset) begin
      hold_vld = 1'b0;
    end else begin
      if (msg_valid && msg_ready && msg_last) last_acc_cyc = cyc;
      if (hold_vld && blk_valid) begin
        check_data("stall_data", blk_data, hold_data);
        check("stall_flags", 64'({blk_first, blk_last}), 64'(hold_data[0] ? 2'b00 : 2'b00) | 64'({last_first, last_last}));
        check("stall_msg_ready", 64'(msg_ready), 64'd0);
      end
      hold_vld  = blk_valid && !blk_ready;
      hold_data = blk_data;
      if (hold_vld) begin
        last_first = blk_first;
        last_last  = blk_last;
      end
      if (blk_valid && blk_ready) begin
        blk_t e;
        last_blk_cyc = cyc;
        last_data    = blk_data;
        last_first   = blk_first;
        last_last    = blk_last;
        blk_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_block: got %0h, expected no block", blk_data);
        end else begin
          n_pass++;
          e = exp_q.pop_front();
          check_data("blk_data", blk_data, e.data);
          check("blk_first", 64'(blk_first), 64'(e.first));
          check("blk_last", 64'(blk_last), 64'(e.last));
        end
      end
    end
  end

  task automatic wait_accept();
    int t = 0;
    @(negedge clk);
    while (!msg_ready) begin
      t++;
      if (t > 2000) begin
        $display("FAIL msg_ready_timeout: got 0, expected 1 within 2000 cycles");
        $fatal(1, "timeout waiting for msg_ready");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input byte_t m[$], input int gap_pct);
    model_push(m);
    for (int i = 0; i < m.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        @(posedge clk);
        #1;
      end
      msg_valid = 1'b1;
      msg_byte  = m[i];
      msg_last  = (i == m.size() - 1);
      wait_accept();
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_msg_ready", 64'(msg_ready), 64'd1);
    check("rst_flags", 64'({blk_valid, blk_first, blk_last}), 64'd0);
    check_data("rst_blk_data", blk_data, '0);
  endtask

  byte_t        m[$];
  vec_t         vecs[7];
  logic [511:0] abc_blk;

  initial begin
    msg_valid = 1'b0;
    msg_byte  = 8'h00;
    msg_last  = 1'b0;
    reset     = 1'b1;
    abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
    vecs[0] = '{len: 55,  fill: 8'h61, nblk: 1, w0: 32'h61616161, w13: 32'h61616180, w15: 32'h000001B8, lat: 2};
    vecs[1] = '{len: 56,  fill: 8'h61, nblk: 2, w0: 32'h00000000, w13: 32'h00000000, w15: 32'h000001C0, lat: 4};
    vecs[2] = '{len: 64,  fill: 8'h61, nblk: 2, w0: 32'h80000000, w13: 32'h00000000, w15: 32'h00000200, lat: 3};
    vecs[3] = '{len: 1,   fill: 8'h00, nblk: 1, w0: 32'h00800000, w13: 32'h00000000, w15: 32'h00000008, lat: 2};
    vecs[4] = '{len: 63,  fill: 8'hFF, nblk: 2, w0: 32'h00000000, w13: 32'h00000000, w15: 32'h000001F8, lat: 4};
    vecs[5] = '{len: 120, fill: 8'h5A, nblk: 3, w0: 32'h00000000, w13: 32'h00000000, w15: 32'h000003C0, lat: 4};
    vecs[6] = '{len: 100, fill: 8'hC3, nblk: 2, w0: 32'hC3C3C3C3, w13: 32'h00000000, w15: 32'h00000320, lat: 2};

    repeat (3) @(posedge clk);
    check_reset_state();
    @(posedge clk);
    #1 reset = 1'b0;

    // "abc": single block, valid two cycles after the last byte.
    m = '{8'h61, 8'h62, 8'h63};
    blk_cnt = 0;
    send_msg(m, 0);
    drain();
    check("abc_blocks", 64'(blk_cnt), 64'd1);
    check_data("abc_block", last_data, abc_blk);
    check("abc_first_last", 64'({last_first, last_last}), 64'b11);
    check("abc_latency", 64'(last_blk_cyc - last_acc_cyc), 64'd2);

    foreach (vecs[v]) begin
      m.delete();
      for (int i = 0; i < vecs[v].len; i++) m.push_back(vecs[v].fill);
      blk_cnt = 0;
      send_msg(m, 0);
      drain();
      check($sformatf("vec%0d_blocks", v), 64'(blk_cnt), 64'(vecs[v].nblk));
      check($sformatf("vec%0d_w0", v), 64'(word(last_data, 0)), 64'(vecs[v].w0));
      check($sformatf("vec%0d_w13", v), 64'(word(last_data, 13)), 64'(vecs[v].w13));
      check($sformatf("vec%0d_w14", v), 64'(word(last_data, 14)), 64'd0);
      check($sformatf("vec%0d_w15", v), 64'(word(last_data, 15)), 64'(vecs[v].w15));
      check($sformatf("vec%0d_latency", v), 64'(last_blk_cyc - last_acc_cyc), 64'(vecs[v].lat));
    end

    // Backpressure: stall a block for 10 cycles, then release it.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    m.delete();
    for (int i = 0; i < 10; i++) m.push_back(byte_t'(8'h10 + i));
    send_msg(m, 0);
    begin
      int t = 0;
      while (!blk_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    repeat (10) @(negedge clk);
    check("bp_valid_held", 64'(blk_valid), 64'd1);
    check("bp_msg_ready", 64'(msg_ready), 64'd0);
    rdy_mode = 1;
    drain();
    @(negedge clk);
    check("bp_msg_ready_back", 64'(msg_ready), 64'd1);

    // Reset mid-fill abandons 20 bytes; the following "abc" is a clean first block.
    for (int i = 0; i < 20; i++) begin
      msg_valid = 1'b1;
      msg_byte  = byte_t'($urandom_range(0, 255));
      msg_last  = 1'b0;
      wait_accept();
    end
    msg_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    check_reset_state();
    @(posedge clk);
    #1 reset = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    blk_cnt = 0;
    send_msg(m, 0);
    drain();
    check("rst_abc_blocks", 64'(blk_cnt), 64'd1);
    check_data("rst_abc_block", last_data, abc_blk);
    check("rst_abc_first_last", 64'({last_first, last_last}), 64'b11);

    // Random messages with idle gaps and random consumer backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      int len;
      len = $urandom_range(1, 160);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(byte_t'($urandom_range(0, 255)));
      send_msg(m, 25);
    end
    drain();
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    check("final_idle_valid", 64'(blk_valid), 64'd0);
    check("final_msg_ready", 64'(msg_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 compression core. It accepts a message as a byte stream, applies FIPS 180-4 padding (a 0x80 byte, zero fill, and a 64-bit big-endian bit length), and presents complete 512-bit blocks on a valid/ready port. System glue maps each block onto the core's sixteen message-word inputs and start strobe, and drives `blk_ready` from the core's idle or done status.

## Interface
Parameters:
- none. All widths are fixed by SHA-256.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `msg_valid`  in  1  `msg_byte` is valid this cycle.
- `msg_ready`  out  1  padder accepts a byte this cycle. A byte transfers when `msg_valid && msg_ready`.
- `msg_byte`  in  8  message byte, in stream order.
- `msg_last`  in  1  qualifies the final byte of the message.
- `blk_valid`  out  1  `blk_data` holds a complete block.
- `blk_ready`  in  1  consumer takes the block. A block transfers when `blk_valid && blk_ready`.
- `blk_data`  out  512  block contents. Stream byte 0 sits in bits [511:504]. Word i = `blk_data[511-32i -: 32]` and drives the core's wi input.
- `blk_first`  out  1  block is the first block of its message; the consumer uses it to reload the IV.
- `blk_last`  out  1  block is the final block of its message; its digest is the message digest.

## Operation
State machine:
- **FILL**
  - `msg_ready`=1.
  - Each accepted byte is written to byte position `idx`; then `idx`++ and `byte_cnt`++.
  - Byte accepted at `idx`=63 with `msg_last`=0 → go to EMIT, with `pend`=FILL.
  - Byte accepted with `msg_last`=1 at position p:
    - p=63 → go to EMIT with `pend`=PAD1, `q`=0.
    - otherwise → go to PAD1 with `q`=p+1.
- **PAD1** (one cycle)
  - Byte q ← 0x80; bytes q+1..63 ← 0x00.
  - If q≤55: bytes 56..63 ← bit length. Then go to EMIT, marked last, with `pend`=FILL.
  - If q≥56: go to EMIT, marked not last, with `pend`=PAD2.
- **PAD2** (one cycle)
  - Bytes 0..55 ← 0x00; bytes 56..63 ← bit length.
  - Go to EMIT, marked last, with `pend`=FILL.
- **EMIT**
  - `blk_valid`=1; `msg_ready`=0.
  - On handshake: go to `pend`, with `idx`←0.
  - When `pend` is FILL after a last block: clear `byte_cnt` and set `first_flag`.

Arithmetic and flags:
- Bit length = `{byte_cnt[60:0], 3'b000}`, big-endian: byte 56 is the MSB.
- `byte_cnt` is 64 bits and wraps modulo 2^64 silently.
- `first_flag` is set at reset and after each last block, and cleared on any non-last block handshake. `blk_first` = `first_flag` during EMIT.

Boundary conditions:
- Zero-length messages are unsupported; every message carries ≥1 byte.
- `blk_data`, `blk_first` and `blk_last` are stable while `blk_valid`=1 and `blk_ready`=0.
- `msg_valid` with `msg_ready`=0: no effect. Upstream holds the byte.
- Stale buffer content never leaks into output: FILL and PAD together overwrite all 64 bytes of every block.
- Reset mid-operation abandons the partial message and any unaccepted block.

## Timing
Reset values:
- state=FILL, `idx`=0, `byte_cnt`=0, `first_flag`=1, buffer=0.
- `msg_ready`=1, `blk_valid`=0, `blk_first`=0, `blk_last`=0, `blk_data`=0.

Throughput:
- One byte per cycle in FILL.
- Full non-last block: `blk_valid` rises the cycle after byte 63 is accepted.

Latency from last-byte acceptance (`blk_ready` tied high):
- p≤54: PAD1 next cycle; `blk_valid` 2 cycles after.
- 55≤p≤62: first block valid at +2 cycles, second block valid at +4 cycles.
- p=63: first block valid at +1 cycle, second block valid at +3 cycles.

Handshake rules:
- `msg_ready` is 0 during PAD1, PAD2 and EMIT.
- `msg_ready` returns to 1 the cycle after a handshake with `pend`=FILL.
- All outputs are registered or decoded from registered state; there is no combinational path from `blk_ready` to `blk_valid`.

## Structure
- Shared package `sha256_pkg` holds:
  - state encoding (FILL, PAD1, PAD2, EMIT);
  - constants BLOCK_BITS=512, BLOCK_BYTES=64, LEN_POS=56;
  - the IV and K constants shared with the compression core.
- No sub-module. The byte-write mux and pad mask are a single `for` loop inside `sha256_msg_padder`.

## Test plan
- **"abc"** (0x61,0x62,0x63, last on 3rd byte) → one block, first=last=1. Word0=0x61626380, words1–14=0, word15=0x00000018. `blk_valid` 2 cycles after the last byte.
- **55 bytes of 0x61** → one block. Byte 55=0x80, words14–15=0x00000000_000001B8.
- **56 bytes of 0x61** → block 1: byte 56=0x80, bytes 57–63=0, first=1, last=0. Block 2: words0–13=0, length=0x1C0, first=0, last=1.
- **64 bytes** → block 1 is all data. Block 2: word0=0x80000000, words15/14 = 0x00000200/0.
- **Backpressure**: hold `blk_ready`=0 for 10 cycles during EMIT → `blk_data` stable, `msg_ready`=0. Handshake on cycle 11.
- **Reset mid-fill** after 20 bytes, then "abc" → output identical to the "abc" case, with `blk_first`=1.
